// File: rtl/qsn_shift_ctrl_len3.sv
// rtl/qsn_shift_ctrl_len3.sv - select/tag sequencer for the length-3 QSN shifter (optional: QSN_CTRL_STALL_CNT_EN)
module qsn_shift_ctrl_len3 #(
  parameter int Z          = 3,
  parameter int SEL_W      = 2,
  parameter int NUM_COLS   = 4,
  parameter int COL_W      = 2,
  parameter int NUM_LAYERS = 2,
  parameter int LAYER_W    = 1,
  parameter int QSN_LAT    = 2
) (
  input  logic                       sys_clk,
  input  logic                       rst,
  input  logic                       cfg_we,
  input  logic [LAYER_W+COL_W-1:0]   cfg_addr,
  input  logic [SEL_W-1:0]           cfg_shift,
  output logic                       cfg_err,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  input  logic                       msg_valid,
  output logic                       msg_ready,
  output logic [SEL_W-1:0]           left_sel,
  output logic [SEL_W-1:0]           right_sel,
  output logic [SEL_W-1:0]           merge_sel,
  output logic                       out_valid,
  output logic [COL_W-1:0]           out_col,
  output logic [LAYER_W-1:0]         out_layer,
  output logic [15:0]                stall_cnt
);

  localparam int ADDR_W = LAYER_W + COL_W;
  localparam int TBL_N  = 1 << ADDR_W;
  localparam logic [SEL_W:0]   Z_L        = (SEL_W+1)'(Z);
  localparam logic [COL_W-1:0]   LAST_COL   = COL_W'(NUM_COLS - 1);
  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);
  // DRAIN is held so that DONE lands on the cycle of the final out_valid
  localparam logic [1:0]       DRAIN_LOAD = 2'(QSN_LAT - 2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  logic [SEL_W-1:0]   r_table [TBL_N];
  logic [COL_W-1:0]   r_col;
  logic [LAYER_W-1:0] r_layer;
  logic [1:0]         r_drain_cnt;
  logic               r_busy;
  logic               r_done;
  logic               r_msg_ready;
  logic               r_cfg_err;
  logic [SEL_W-1:0]   r_left;
  logic [SEL_W-1:0]   r_right;
  logic [SEL_W-1:0]   r_merge;

  logic               r_vpipe     [QSN_LAT];
  logic [COL_W-1:0]   r_col_pipe  [QSN_LAT];
  logic [LAYER_W-1:0] r_layer_pipe[QSN_LAT];

  logic               w_beat;
  logic               w_cfg_ok;
  logic [SEL_W-1:0]   w_entry;
  logic [SEL_W-1:0]   w_left;
  logic [SEL_W-1:0]   w_right;
  logic [SEL_W-1:0]   w_merge;

  assign w_beat   = msg_valid & r_msg_ready;
  assign w_cfg_ok = cfg_we && (r_state == ST_IDLE) && ({1'b0, cfg_shift} < Z_L);
  assign w_entry  = r_table[{r_layer, r_col}];

  // Map the current shift factor to the three switch selects of the shifter
  always_comb begin
    w_left  = '0;
    w_right = '0;
    w_merge = '0;
    case (w_entry)
      2'd0: begin w_left = 2'd0; w_right = 2'd0; w_merge = 2'b11; end
      2'd1: begin w_left = 2'd1; w_right = 2'd2; w_merge = 2'b01; end
      2'd2: begin w_left = 2'd2; w_right = 2'd1; w_merge = 2'b00; end
      default: begin w_left = '0; w_right = '0; w_merge = '0; end
    endcase
  end

  // Shift-factor table: writable only while idle and with an in-range factor
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TBL_N; i++) r_table[i] <= '0;
    end else if (w_cfg_ok) begin
      r_table[cfg_addr] <= cfg_shift;
    end
  end

  // Rejected writes flag an error one cycle after the attempt
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) r_cfg_err <= 1'b0;
    else     r_cfg_err <= cfg_we && !w_cfg_ok;
  end

  // Run sequencer: walks the table once per start and issues registered selects
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_col       <= '0;
      r_layer     <= '0;
      r_drain_cnt <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_msg_ready <= 1'b0;
      r_left      <= '0;
      r_right     <= '0;
      r_merge     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state     <= ST_RUN;
            r_col       <= '0;
            r_layer     <= '0;
            r_busy      <= 1'b1;
            r_msg_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_beat) begin
            r_left  <= w_left;
            r_right <= w_right;
            r_merge <= w_merge;
            if (r_col == LAST_COL) begin
              r_col <= '0;
              if (r_layer == LAST_LAYER) begin
                r_state     <= ST_DRAIN;
                r_msg_ready <= 1'b0;
                r_drain_cnt <= DRAIN_LOAD;
              end else begin
                r_layer <= r_layer + LAYER_W'(1);
              end
            end else begin
              r_col <= r_col + COL_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (r_drain_cnt == 2'd0) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt - 2'd1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Valid/tag pipe mirroring the shifter's merge-select and output registers
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < QSN_LAT; i++) begin
        r_vpipe[i]      <= 1'b0;
        r_col_pipe[i]   <= '0;
        r_layer_pipe[i] <= '0;
      end
    end else begin
      r_vpipe[0]      <= w_beat;
      r_col_pipe[0]   <= r_col;
      r_layer_pipe[0] <= r_layer;
      for (int i = 1; i < QSN_LAT; i++) begin
        r_vpipe[i]      <= r_vpipe[i-1];
        r_col_pipe[i]   <= r_col_pipe[i-1];
        r_layer_pipe[i] <= r_layer_pipe[i-1];
      end
    end
  end

`ifdef QSN_CTRL_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Count starved RUN cycles; cleared at run start, saturating, held after done
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_stall_cnt <= '0;
    end else if ((r_state == ST_RUN) && !msg_valid && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = 16'h0000;
`endif

  assign cfg_err   = r_cfg_err;
  assign busy      = r_busy;
  assign done      = r_done;
  assign msg_ready = r_msg_ready;
  assign left_sel  = r_left;
  assign right_sel = r_right;
  assign merge_sel = r_merge;
  assign out_valid = r_vpipe[QSN_LAT-1];
  assign out_col   = r_col_pipe[QSN_LAT-1];
  assign out_layer = r_layer_pipe[QSN_LAT-1];

endmodule

// File: tb/tb_qsn_shift_ctrl_len3.sv
// tb/tb_qsn_shift_ctrl_len3.sv - directed self-checking bench for qsn_shift_ctrl_len3
module tb_qsn_shift_ctrl_len3;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [1:0]  cfg_shift;
  logic        cfg_err;
  logic        start;
  logic        busy;
  logic        done;
  logic        msg_valid;
  logic        msg_ready;
  logic [1:0]  left_sel;
  logic [1:0]  right_sel;
  logic [1:0]  merge_sel;
  logic        out_valid;
  logic [1:0]  out_col;
  logic        out_layer;
  logic [15:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int NC = 32;

  logic        rec_ov   [NC];
  logic        rec_done [NC];
  logic        rec_busy [NC];
  logic        rec_err  [NC];
  logic        rec_mr   [NC];
  logic [1:0]  rec_col  [NC];
  logic        rec_layer[NC];
  logic [1:0]  rec_l    [NC];
  logic [1:0]  rec_r    [NC];
  logic [1:0]  rec_m    [NC];
  logic [15:0] rec_stall[NC];

  logic        rc_busy, rc_ov, rc_mr;
  logic [1:0]  rc_l, rc_r, rc_m;

  // table {L0: 0,1,2,1; L1: 2,2,0,1} -> hand-encoded selects per beat
  logic [1:0] tbl_val[8] = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd0, 2'd1};
  logic [1:0] exp_l  [8] = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd0, 2'd1};
  logic [1:0] exp_r  [8] = '{2'd0, 2'd2, 2'd1, 2'd2, 2'd1, 2'd1, 2'd0, 2'd2};
  logic [1:0] exp_m  [8] = '{2'd3, 2'd1, 2'd0, 2'd1, 2'd0, 2'd0, 2'd3, 2'd1};

  qsn_shift_ctrl_len3 dut (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_shift (cfg_shift),
    .cfg_err   (cfg_err),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .msg_valid (msg_valid),
    .msg_ready (msg_ready),
    .left_sel  (left_sel),
    .right_sel (right_sel),
    .merge_sel (merge_sel),
    .out_valid (out_valid),
    .out_col   (out_col),
    .out_layer (out_layer),
    .stall_cnt (stall_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic write_cfg(input logic [2:0] a, input logic [1:0] s, output logic err);
    cfg_we = 1'b1; cfg_addr = a; cfg_shift = s;
    step;
    err = cfg_err;
    cfg_we = 1'b0;
  endtask

  // cycle 0 carries the start pulse; cycle k inputs are applied after recording cycle k
  task automatic do_run(input logic [31:0] vpat, input int start_a, input int start_b,
                        input int cfg_cyc, input int rst_cyc);
    cfg_we = 1'b0; start = 1'b1; msg_valid = 1'b0;
    rec_ov[0] = 0; rec_done[0] = 0; rec_busy[0] = 0; rec_err[0] = 0; rec_mr[0] = 0;
    for (int k = 1; k < NC; k++) begin
      step;
      rst = 1'b0;
      rec_ov[k] = out_valid;  rec_done[k] = done;   rec_busy[k] = busy;
      rec_err[k] = cfg_err;   rec_mr[k] = msg_ready;
      rec_col[k] = out_col;   rec_layer[k] = out_layer;
      rec_l[k] = left_sel;    rec_r[k] = right_sel; rec_m[k] = merge_sel;
      rec_stall[k] = stall_cnt;
      start     = (k == start_a) || (k == start_b);
      msg_valid = vpat[k-1];
      cfg_we    = (k == cfg_cyc);
      cfg_addr  = 3'd2;
      cfg_shift = 2'd0;
      if (k == rst_cyc) begin
        #2 rst = 1'b1;
        #1;
        rc_busy = busy; rc_ov = out_valid; rc_mr = msg_ready;
        rc_l = left_sel; rc_r = right_sel; rc_m = merge_sel;
      end
    end
    start = 1'b0; msg_valid = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_shift = '0; start = 1'b0; msg_valid = 1'b0;
    step; step;
    rst = 1'b0;
    step;
    n_checks++;
    if ({busy, done, msg_ready, out_valid, cfg_err} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 00000", {busy, done, msg_ready, out_valid, cfg_err});
    end
    n_checks++;
    if ({left_sel, right_sel, merge_sel} !== 6'b0) begin
      n_fail++; $display("FAIL reset_selects: got %b want 000000", {left_sel, right_sel, merge_sel});
    end
    n_checks++;
    if ({out_col, out_layer, stall_cnt} !== 19'b0) begin
      n_fail++; $display("FAIL reset_tags_stall: got col=%0d layer=%0d stall=%0d want 0", out_col, out_layer, stall_cnt);
    end
  endtask

  task automatic test_program;
    logic e;
    for (int i = 0; i < 8; i++) begin
      write_cfg(3'(i), tbl_val[i], e);
      n_checks++;
      if (e !== 1'b0) begin
        n_fail++; $display("FAIL program_err[%0d]: got %b want 0", i, e);
      end
    end
    step;
  endtask

  task automatic test_full_run;
    logic exp_ov, exp_dn, exp_bz, exp_mr;
    do_run(32'hFFFF_FFFF, -1, -1, -1, -1);
    for (int k = 1; k < 20; k++) begin
      exp_ov = (k >= 3) && (k <= 10);
      exp_dn = (k == 10);
      exp_bz = (k >= 1) && (k <= 10);
      exp_mr = (k >= 1) && (k <= 8);
      n_checks++;
      if ({rec_ov[k], rec_done[k], rec_busy[k], rec_mr[k]} !== {exp_ov, exp_dn, exp_bz, exp_mr}) begin
        n_fail++;
        $display("FAIL full_flags cyc%0d: got ov/done/busy/rdy=%b want %b", k,
                 {rec_ov[k], rec_done[k], rec_busy[k], rec_mr[k]}, {exp_ov, exp_dn, exp_bz, exp_mr});
      end
      if (exp_ov) begin
        n_checks++;
        if ({rec_layer[k], rec_col[k]} !== 3'(k - 3)) begin
          n_fail++; $display("FAIL full_tag cyc%0d: got L%0d C%0d want %0d", k, rec_layer[k], rec_col[k], k - 3);
        end
      end
    end
    for (int j = 0; j < 8; j++) begin
      n_checks++;
      if ({rec_l[j+2], rec_r[j+2], rec_m[j+2]} !== {exp_l[j], exp_r[j], exp_m[j]}) begin
        n_fail++;
        $display("FAIL full_sel beat%0d: got l=%0d r=%0d m=%b want l=%0d r=%0d m=%b", j,
                 rec_l[j+2], rec_r[j+2], rec_m[j+2], exp_l[j], exp_r[j], exp_m[j]);
      end
    end
    n_checks++;
    if ({rec_l[15], rec_r[15], rec_m[15]} !== 6'b01_10_01) begin
      n_fail++; $display("FAIL full_sel_hold: got %b want 011001", {rec_l[15], rec_r[15], rec_m[15]});
    end
    n_checks++;
    if (rec_stall[10] !== 16'd0) begin
      n_fail++; $display("FAIL full_stall: got %0d want 0", rec_stall[10]);
    end
  endtask

  task automatic test_cfg_err;
    logic e;
    write_cfg(3'd1, 2'd3, e);
    n_checks++;
    if (e !== 1'b1) begin
      n_fail++; $display("FAIL cfg_err_range: got %b want 1", e);
    end
    step;
    n_checks++;
    if (cfg_err !== 1'b0) begin
      n_fail++; $display("FAIL cfg_err_pulse: got %b want 0", cfg_err);
    end
    do_run(32'hFFFF_FFFF, -1, -1, 4, -1);
    n_checks++;
    if ({rec_err[4], rec_err[5], rec_err[6]} !== 3'b010) begin
      n_fail++; $display("FAIL cfg_err_busy: got %b want 010", {rec_err[4], rec_err[5], rec_err[6]});
    end
    do_run(32'hFFFF_FFFF, -1, -1, -1, -1);
    n_checks++;
    if ({rec_l[3], rec_r[3], rec_m[3]} !== 6'b01_10_01) begin
      n_fail++; $display("FAIL cfg_keep_c1: got %b want 011001", {rec_l[3], rec_r[3], rec_m[3]});
    end
    n_checks++;
    if ({rec_l[4], rec_r[4], rec_m[4]} !== 6'b10_01_00) begin
      n_fail++; $display("FAIL cfg_keep_c2: got %b want 100100", {rec_l[4], rec_r[4], rec_m[4]});
    end
  endtask

  task automatic test_gaps;
    logic exp_ov;
    logic [15:0] exp_stall;
`ifdef QSN_CTRL_STALL_CNT_EN
    exp_stall = 16'd7;
`else
    exp_stall = 16'd0;
`endif
    do_run(32'h5555_5555, -1, -1, -1, -1);
    for (int k = 1; k < 22; k++) begin
      exp_ov = (k >= 3) && (k <= 17) && (k % 2 == 1);
      n_checks++;
      if (rec_ov[k] !== exp_ov) begin
        n_fail++; $display("FAIL gap_ov cyc%0d: got %b want %b", k, rec_ov[k], exp_ov);
      end
      if (exp_ov) begin
        n_checks++;
        if ({rec_layer[k], rec_col[k]} !== 3'((k - 3) / 2)) begin
          n_fail++; $display("FAIL gap_tag cyc%0d: got L%0d C%0d want %0d", k, rec_layer[k], rec_col[k], (k - 3) / 2);
        end
      end
    end
    n_checks++;
    if ({rec_done[16], rec_done[17], rec_done[18]} !== 3'b010) begin
      n_fail++; $display("FAIL gap_done: got %b want 010", {rec_done[16], rec_done[17], rec_done[18]});
    end
    n_checks++;
    if (rec_stall[17] !== exp_stall) begin
      n_fail++; $display("FAIL gap_stall: got %0d want %0d", rec_stall[17], exp_stall);
    end
    n_checks++;
    if (rec_stall[25] !== exp_stall) begin
      n_fail++; $display("FAIL gap_stall_hold: got %0d want %0d", rec_stall[25], exp_stall);
    end
  endtask

  task automatic test_start_ignored;
    int n_done, n_ov, n_busy_after;
    do_run(32'hFFFF_FFFF, 4, 9, -1, -1);
    n_done = 0; n_ov = 0; n_busy_after = 0;
    for (int k = 1; k < NC; k++) begin
      n_done += int'(rec_done[k]);
      n_ov   += int'(rec_ov[k]);
      if (k >= 11) n_busy_after += int'(rec_busy[k]);
    end
    n_checks++;
    if (n_done !== 1 || rec_done[10] !== 1'b1) begin
      n_fail++; $display("FAIL start_ign_done: got count=%0d at10=%b want 1/1", n_done, rec_done[10]);
    end
    n_checks++;
    if (n_ov !== 8) begin
      n_fail++; $display("FAIL start_ign_outputs: got %0d want 8", n_ov);
    end
    n_checks++;
    if (n_busy_after !== 0) begin
      n_fail++; $display("FAIL start_ign_busy: got %0d busy cycles after done want 0", n_busy_after);
    end
  endtask

  task automatic test_reset_mid;
    int n_done, n_ov;
    do_run(32'hFFFF_FFFF, -1, -1, -1, 3);
    n_checks++;
    if ({rc_busy, rc_ov, rc_mr} !== 3'b000) begin
      n_fail++; $display("FAIL rst_mid_flags: got busy/ov/rdy=%b want 000", {rc_busy, rc_ov, rc_mr});
    end
    n_checks++;
    if ({rc_l, rc_r, rc_m} !== 6'b0) begin
      n_fail++; $display("FAIL rst_mid_sel: got %b want 000000", {rc_l, rc_r, rc_m});
    end
    n_done = 0; n_ov = 0;
    for (int k = 4; k < NC; k++) begin
      n_done += int'(rec_done[k]);
      n_ov   += int'(rec_ov[k]);
    end
    n_checks++;
    if (n_done !== 0 || n_ov !== 0) begin
      n_fail++; $display("FAIL rst_mid_quiet: got done=%0d ov=%0d want 0/0", n_done, n_ov);
    end
    do_run(32'hFFFF_FFFF, -1, -1, -1, -1);
    n_ov = 0;
    for (int k = 1; k < NC; k++) n_ov += int'(rec_ov[k]);
    n_checks++;
    if (n_ov !== 8 || rec_done[10] !== 1'b1) begin
      n_fail++; $display("FAIL rst_rerun: got ov=%0d done10=%b want 8/1", n_ov, rec_done[10]);
    end
    n_checks++;
    if ({rec_l[3], rec_r[3], rec_m[3]} !== 6'b00_00_11) begin
      n_fail++; $display("FAIL rst_table_clear: got %b want 000011", {rec_l[3], rec_r[3], rec_m[3]});
    end
  endtask

  initial begin
    test_reset;
    test_program;
    test_full_run;
    test_cfg_err;
    test_gaps;
    test_start_ignored;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/qsn_shift_ctrl_len3.md
Name: qsn_shift_ctrl_len3

Overview:
- Sequencer for the length-3 QSN cyclic shifter used in the partial message-passing path (Z=3, 3-bit messages, one switch per message bit).
- Holds a programmable shift-factor table indexed by (layer, block column).
- Walks the table once per start: accepts one message beat per column, drives left_sel/right_sel/merge_sel for the shifter, and tracks shifter latency so out_valid and tags align with the shifter's registered output.

Parameters:
- Z, 3, lifting size; the shift factor range is 0..Z-1.
- SEL_W, 2, width of the shift factor and of each select bus.
- NUM_COLS, 4, block columns per layer.
- COL_W, 2, column index width (clog2 NUM_COLS).
- NUM_LAYERS, 2, layers per run.
- LAYER_W, 1, layer index width.
- QSN_LAT, 2, cycles from select issue to valid shifter output.

Ports:
- sys_clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  LAYER_W+COL_W  table index: {layer, col}.
- cfg_shift  in  SEL_W  shift factor.
- cfg_err  out  1  one-cycle pulse when a write is rejected.
- start  in  1  start-of-run pulse.
- busy  out  1  high from the start-accept cycle through the DONE cycle.
- done  out  1  one-cycle pulse on run completion.
- msg_valid  in  1  upstream message beat present.
- msg_ready  out  1  controller accepts the beat.
- left_sel  out  SEL_W  to the shifter.
- right_sel  out  SEL_W  to the shifter.
- merge_sel  out  SEL_W  to the shifter.
- out_valid  out  1  shifter output valid this cycle.
- out_col  out  COL_W  column tag of the valid output.
- out_layer  out  LAYER_W  layer tag of the valid output.
- stall_cnt  out  16  starved-cycle counter; see Optional Feature.

Behaviour:
- Reset: asynchronous, active-high.
  - All outputs are 0, state is IDLE, counters are 0, all table entries are 0.
  - Reset mid-run aborts immediately; no done pulse is produced.
- Table writes:
  - Accepted only in IDLE with cfg_shift < Z.
  - A write while busy, or with cfg_shift >= Z, is dropped and cfg_err pulses in the next cycle.
- Select encoding (combinational from the current table entry; all select outputs are registered):
  - s=0: left=0, right=0, merge=2'b11.
  - s=1: left=1, right=2, merge=2'b01.
  - s=2: left=2, right=1, merge=2'b00.
  - Selects hold their last value when no beat issues.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start=1 -> RUN; col=0, layer=0, busy=1 from the next cycle.
  - RUN: msg_ready=1.
    - Beat = msg_valid & msg_ready.
    - On a beat: selects are registered from table[layer, col], and the pair {layer, col} enters a QSN_LAT-deep valid/tag shift pipe.
    - col increments; on col=NUM_COLS-1 it wraps to 0 and layer increments.
    - Beat on (NUM_LAYERS-1, NUM_COLS-1) -> DRAIN; msg_ready=0 from the next cycle.
  - DRAIN: wait until the valid pipe is empty -> DONE.
  - DONE: done=1 for one cycle, busy=1 -> IDLE.
- start is ignored unless in IDLE.
- Latency: a beat accepted at cycle t gives out_valid=1 with its tags at cycle t+QSN_LAT. This matches the shifter's merge-select register plus output register.
- Gaps (msg_valid=0 in RUN) produce matching out_valid gaps; there is no downstream backpressure.
- Total tagged outputs per run = NUM_LAYERS*NUM_COLS, with no duplicates and no drops.

Optional Feature:
- Macro: QSN_CTRL_STALL_CNT_EN.
- Defined:
  - stall_cnt counts RUN cycles with msg_valid=0.
  - It clears on run start, saturates at 16'hFFFF, and holds after done until the next start.
- Undefined: stall_cnt is tied to 0 and no counter logic is present.

Test Plan:
- Reset, then program table {L0: 0,1,2,1; L1: 2,2,0,1}, start, msg_valid held 1.
  - 8 beats; out_valid high for 8 consecutive cycles starting 2 cycles after the first beat.
  - Tags run (0,0)..(1,3).
  - Selects for L0 C1 = left 1, right 2, merge 01.
  - done 2 cycles after the last beat.
- Write cfg_shift=3 in IDLE, and any write while busy -> cfg_err pulses, the table entry is unchanged, and its read-back via the run selects is unchanged.
- Run with msg_valid toggling 1,0,1,0 -> out_valid shows the identical gap pattern shifted by 2.
  - With QSN_CTRL_STALL_CNT_EN, stall_cnt = 7 at done.
- start pulsed during RUN and during DRAIN -> no restart, and exactly one done.
- Assert rst on the 3rd beat -> busy, out_valid and selects are 0 immediately, the table is 0, and no done pulse occurs.
  - A new start after release completes with 8 outputs.
